// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Front end of a single-cycle core. Owns the PC, fetches one 32-bit word at
//   a time from instruction memory, splits it into decode fields and hands it
//   downstream under valid/ready. Branch/jump resolution can redirect the PC
//   at any time.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   imem_req/imem_addr    : one-cycle fetch strobe and word address
//   imem_valid/imem_rdata : memory response (one request outstanding)
//   issue_valid/ready     : downstream handshake for the held instruction
//   Instruction, pc_out   : raw word and its address
//   Opcode, Funct, rs1, rs2, rd, imm : decode fields of the held word
//   redirect_valid/pc     : PC replacement, squashes whatever is in flight
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] Instruction,
    output logic [31:0] pc_out,
    output logic [6:0]  Opcode,
    output logic [3:0]  Funct,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;

    state_t      state, state_n;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        drop;
    // Cleared by reset, set one cycle later: keeps imem_req low while reset is
    // held and for the release cycle, without an input-to-output path.
    logic        run;

    logic        unused_bits;
    assign unused_bits = ^redirect_pc[1:0];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_n = state;
        unique case (state)
            // A request always goes out when running; a redirect in the same
            // cycle only marks its response stale, so WAIT either way.
            FETCH: if (run) state_n = WAIT;
            // A redirect coinciding with the response consumes that response
            // as stale: nothing else is outstanding, so refetch directly.
            WAIT:  if (imem_valid) state_n = (drop || redirect_valid) ? FETCH : ISSUE;
            ISSUE: if (redirect_valid || issue_ready) state_n = FETCH;
            default: state_n = FETCH;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        imem_req    = run && (state == FETCH);
        imem_addr   = pc;
        issue_valid = (state == ISSUE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            drop  <= 1'b0;
            ir    <= 32'd0;
            ir_pc <= 32'd0;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;

            if (redirect_valid)
                pc <= {redirect_pc[31:2], 2'b00};
            else if (state == ISSUE && issue_ready)
                pc <= pc + 32'd4;

            unique case (state)
                FETCH: if (redirect_valid && run) drop <= 1'b1;
                // Only one response is ever outstanding, so it clears drop no
                // matter how many redirects arrived while waiting.
                WAIT: begin
                    if (imem_valid)          drop <= 1'b0;
                    else if (redirect_valid) drop <= 1'b1;
                end
                default: ;
            endcase

            if (state == WAIT && imem_valid && !drop && !redirect_valid) begin
                ir    <= imem_rdata;
                ir_pc <= pc;
            end
        end
    end

    // ---------------- decode (from ir only) ----------------
    assign Instruction = ir;
    assign pc_out      = ir_pc;
    assign Opcode      = ir[6:0];
    assign Funct       = {ir[30], ir[14:12]};
    assign rs1         = ir[19:15];
    assign rs2         = ir[24:20];
    assign rd          = ir[11:7];

    always_comb begin
        imm = 32'd0;
        unique case (ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm = {{20{ir[31]}}, ir[31:20]};
            7'b0100011:
                imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011:
                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {ir[31:12], 12'd0};
            7'b1101111:
                imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        issue_valid;
    logic        issue_ready = 1'b1;
    logic [31:0] Instruction, pc_out, imm;
    logic [6:0]  Opcode;
    logic [3:0]  Funct;
    logic [4:0]  rs1, rs2, rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    instr_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .Instruction(Instruction), .pc_out(pc_out), .Opcode(Opcode), .Funct(Funct),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, word, imm;
        logic [6:0]  opc;
        logic [3:0]  funct;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0, errors = 0;
    int          accepts = 0;
    logic [31:0] model_pc;
    int          lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_q = 32'd0;
    bit          fixed1 = 1'b0;
    int          rel = 0;
    bit          prev_rst = 1'b0;
    int          idle = 0;

    // Instruction memory contents: a few fixed words, hashed words elsewhere
    // with opcodes drawn from every immediate format.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [3:0]  k;
        logic [6:0]  op;
        case (a)
            32'h100: return 32'h00500093;
            32'h104: return 32'hFE112E23;
            32'h108: return 32'hFE000EE3;
            32'h10C: return 32'h123452B7;
            32'h110: return 32'h004000EF;
            32'h114: return 32'h40B50533;
            default: ;
        endcase
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 13);
        k = h[3:0];
        if (k >= 4'd10) k = k - 4'd6;
        case (k)
            4'd0: op = 7'h13;  4'd1: op = 7'h03;  4'd2: op = 7'h67;
            4'd3: op = 7'h23;  4'd4: op = 7'h63;  4'd5: op = 7'h37;
            4'd6: op = 7'h17;  4'd7: op = 7'h6F;  4'd8: op = 7'h33;
            default: op = 7'h0B;
        endcase
        return {h[31:7], op};
    endfunction

    // Immediate by arithmetic shifts of the signed word.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [31:0] sw;
        logic [31:0] top;
        sw = w;
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin top = sw >>> 20; return top; end
            7'h23: begin top = sw >>> 25; return (top << 5) | {27'd0, w[11:7]}; end
            7'h63: begin
                top = sw >>> 31;
                return (top << 12) | {20'd0, w[7], w[30:25], w[11:8], 1'b0};
            end
            7'h37, 7'h17: return w & 32'hFFFF_F000;
            7'h6F: begin
                top = sw >>> 31;
                return (top << 20) | {12'd0, w[19:12], w[20], w[30:21], 1'b0};
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.word  = mem_word(pc);
        e.opc   = e.word[6:0];
        e.funct = {e.word[30], e.word[14:12]};
        e.rs1   = e.word[19:15];
        e.rs2   = e.word[24:20];
        e.rd    = e.word[11:7];
        e.imm   = ref_imm(e.word);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle of stimulus, driven at the falling edge: memory responder,
    // handshake/redirect inputs, and the program-order model that pushes the
    // next instruction the core must issue.
    task automatic step(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc);
        imem_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_word(mem_addr_q);
            end
        end
        if (imem_valid || rst) rv = 1'b0;
        if (imem_req === 1'b1 && !rst) begin
            mem_cnt    = lat;
            mem_addr_q = imem_addr;
        end
        if (rst) mem_cnt = 0;
        reset = rst; issue_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        if (rst) begin
            model_pc = RPC;
            sbq.delete();
            sbq.push_back(mk(model_pc));
        end else if (rv) begin
            model_pc = {rpc[31:2], 2'b00};
            sbq.delete();
            sbq.push_back(mk(model_pc));
        end else if (issue_valid === 1'b1 && rdy) begin
            model_pc = model_pc + 32'd4;
            sbq.push_back(mk(model_pc));
        end
    endtask

    // Monitor: samples mid-cycle, after inputs settle and before the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (prev_rst) begin
                chk("rst_req", 32'(imem_req), 32'd0);
                chk("rst_issue", 32'(issue_valid), 32'd0);
                chk("rst_instr", Instruction, 32'd0);
                chk("rst_pcout", pc_out, 32'd0);
                chk("rst_imm", imm, 32'd0);
                chk("rst_fields", 32'({Opcode, Funct, rs1, rs2, rd}), 32'd0);
            end
            if (reset) rel = 0; else rel++;
            if (!reset && rel == 1) begin
                chk("release_noreq", 32'(imem_req), 32'd0);
                chk("release_noissue", 32'(issue_valid), 32'd0);
            end
            if (!reset && rel == 2) begin
                chk("first_req", 32'(imem_req), 32'd1);
                chk("first_addr", imem_addr, RPC);
            end
            if (fixed1 && !reset && rel == 4) chk("first_issue", 32'(issue_valid), 32'd1);

            if (imem_req === 1'b1) begin
                chk("req_with_issue", 32'(issue_valid), 32'd0);
                if (!reset && !redirect_valid && sbq.size() > 0)
                    chk("fetch_addr", imem_addr, sbq[0].pc);
            end

            if (issue_valid === 1'b1 && !reset && !redirect_valid) begin
                if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                else begin
                    e = sbq[0];
                    chk("pc_out", pc_out, e.pc);
                    chk("instr", Instruction, e.word);
                    chk("opcode", 32'(Opcode), 32'(e.opc));
                    chk("funct", 32'(Funct), 32'(e.funct));
                    chk("regs", 32'({rs1, rs2, rd}), 32'({e.rs1, e.rs2, e.rd}));
                    chk("imm", imm, e.imm);
                    if (issue_ready) begin
                        // Hand-decoded values of the fixed words.
                        case (pc_out)
                            32'h100: begin
                                chk("lit_addi_imm", imm, 32'd5);
                                chk("lit_addi_opc", 32'(Opcode), 32'h13);
                                chk("lit_addi_rd", 32'(rd), 32'd1);
                            end
                            32'h104: chk("lit_s_imm", imm, 32'hFFFF_FFFC);
                            32'h108: chk("lit_b_imm", imm, 32'hFFFF_FFFC); // beq x0,x0,-4
                            32'h10C: chk("lit_u_imm", imm, 32'h1234_5000);
                            32'h110: chk("lit_j_imm", imm, 32'h0000_0004);
                            32'h114: begin
                                chk("lit_r_imm", imm, 32'd0);
                                chk("lit_r_funct", 32'(Funct), 32'h8);
                            end
                            default: ;
                        endcase
                        void'(sbq.pop_front());
                        accepts++;
                        idle = 0;
                    end
                end
            end
            if (!reset) idle++;
            if (idle >= 300) begin
                chk("no_progress", 32'(idle), 32'd0);
                idle = 0;
            end
            prev_rst = reset;
        end
    end

    initial begin : driver
        int bp, sr, rst_left;
        bit req, rs, rv;
        logic [31:0] rp;

        // Reset, 1-cycle memory, first instructions with a 4-cycle stall on 0x104.
        lat = 1; fixed1 = 1'b1;
        repeat (3) begin @(negedge clk); step(1, 1, 0, 32'd0); end
        bp = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (issue_valid && pc_out == 32'h104 && bp < 4) begin step(0, 0, 0, 32'd0); bp++; end
            else step(0, 1, 0, 32'd0);
        end
        fixed1 = 1'b0;

        // Redirect on an issuing instruction with ready also high.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (issue_valid) begin step(0, 1, 1, 32'h203); break; end
            step(0, 1, 0, 32'd0);
        end
        repeat (10) begin @(negedge clk); step(0, 1, 0, 32'd0); end

        // Redirect while waiting on a 3-cycle memory.
        lat = 3;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); req = imem_req; step(0, 1, 0, 32'd0);
            if (req) break;
        end
        @(negedge clk); step(0, 1, 1, 32'h400);
        repeat (20) begin @(negedge clk); step(0, 1, 0, 32'd0); end

        // Reset while waiting, response landing in the reset cycle.
        lat = 2;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); req = imem_req; step(0, 1, 0, 32'd0);
            if (req) break;
        end
        @(negedge clk); step(0, 1, 0, 32'd0);
        @(negedge clk); step(1, 1, 0, 32'd0);
        @(negedge clk); step(1, 1, 0, 32'd0);
        lat = 1;
        repeat (20) begin @(negedge clk); step(0, 1, 0, 32'd0); end

        // Random traffic.
        rst_left = 0; sr = 10;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            lat = $urandom_range(1, 4);
            if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 2);
            rs = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            if (rs) sr = 0; else sr++;
            rv = !rs && sr > 2 && $urandom_range(0, 19) == 0;
            case ($urandom_range(0, 3))
                0: rp = 32'h100 + 32'($urandom_range(0, 5) << 2);
                1: rp = $urandom & 32'h0000_0FFF;
                2: rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: rp = $urandom;
            endcase
            step(rs, $urandom_range(0, 9) < 7, rv, rp);
        end
        repeat (10) begin @(negedge clk); step(0, 1, 0, 32'd0); end
        chk("progress", 32'(accepts > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
